// File: rtl/srt_pkg.sv
// Shared constants and types for the SRT2 divider / shift_add_mac pair.
// Latency-related constants come from one place so both blocks and their
// benches agree on iteration counts.
// Build option: define RADIX4_EN to retire two multiplier bits per step.
package srt_pkg;

  localparam int unsigned WID = 64;
  localparam int unsigned ACC_W = 2 * WID;
  localparam int unsigned SHAMT_W = $clog2(ACC_W);

`ifdef RADIX4_EN
  localparam int unsigned STEP_BITS = 2;
`else
  localparam int unsigned STEP_BITS = 1;
`endif

  localparam int unsigned ITERS = WID / STEP_BITS;
  localparam int unsigned CNT_W = $clog2(ITERS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_mac_if.sv
// Request/response bus shared by shift_add_mac and the SRT2 divider.
// master: drives operands and valid; slave: returns busy, ready, result, overflow.
interface shift_add_mac_if;
  import srt_pkg::*;

  logic [WID-1:0]   multiplicand;
  logic [WID-1:0]   multiplier;
  logic [WID-1:0]   addend;
  logic             valid;
  logic             busy;
  logic             ready;
  logic [ACC_W-1:0] result;
  logic             overflow;

  modport master (
    output multiplicand, multiplier, addend, valid,
    input  busy, ready, result, overflow
  );

  modport slave (
    input  multiplicand, multiplier, addend, valid,
    output busy, ready, result, overflow
  );

endinterface

// File: rtl/shift_add_mac_step.sv
// mac_step: one shift-add iteration, purely combinational.
// Ports: acc (running sum), a (multiplicand), a3 (3*a, RADIX4_EN only),
//        b_bits (multiplier bits for this step), cnt (iteration index),
//        acc_next_c (acc + selected partial product << STEP_BITS*cnt).
// Build option: RADIX4_EN selects {0,A,2A,3A} from two multiplier bits.
module mac_step
  import srt_pkg::*;
(
  input  logic [ACC_W-1:0]     acc,
  input  logic [WID-1:0]       a,
`ifdef RADIX4_EN
  input  logic [WID+1:0]       a3,
`endif
  input  logic [STEP_BITS-1:0] b_bits,
  input  logic [CNT_W-1:0]     cnt,
  output logic [ACC_W-1:0]     acc_next_c
);

  logic [WID+1:0]   pp_c;
  logic [SHAMT_W-1:0] shamt_c;

  // Partial-product select and weighted add.
  always_comb begin
    pp_c = '0;
`ifdef RADIX4_EN
    case (b_bits)
      2'd1:    pp_c = {2'b00, a};
      2'd2:    pp_c = {1'b0, a, 1'b0};
      2'd3:    pp_c = a3;
      default: pp_c = '0;
    endcase
`else
    if (b_bits[0]) pp_c = {2'b00, a};
`endif
    shamt_c    = SHAMT_W'(SHAMT_W'(cnt) << (STEP_BITS - 1));
    acc_next_c = acc + (ACC_W'(pp_c) << shamt_c);
  end

endmodule

// File: rtl/shift_add_mac.sv
// shift_add_mac: sequential unsigned multiply-accumulate, result = A*B + C.
// Recomposes dividend = quotient*divisor + remainder from SRT2 divider output.
// Ports: clk, rst (synchronous, active-high), bus (shift_add_mac_if.slave):
//   multiplicand/multiplier/addend/valid in; busy/ready/result/overflow out.
// Timing: valid sampled in IDLE; ITERS RUN cycles; result loads on the edge
// entering DONE; ready pulses one cycle on the edge leaving DONE.
// Build option: RADIX4_EN halves RUN length (two multiplier bits per step).
module shift_add_mac
  import srt_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  shift_add_mac_if.slave bus
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WID-1:0]     a_q;
  logic [WID-1:0]     b_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_next_c;
`ifdef RADIX4_EN
  logic [WID+1:0]     a3_q;
`endif

  mac_step u_step (
    .acc        (acc_q),
    .a          (a_q),
`ifdef RADIX4_EN
    .a3         (a3_q),
`endif
    .b_bits     (b_q[STEP_BITS-1:0]),
    .cnt        (cnt),
    .acc_next_c (acc_next_c)
  );

  // FSM, operand/accumulator registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
`ifdef RADIX4_EN
      a3_q         <= '0;
`endif
      bus.busy     <= 1'b0;
      bus.ready    <= 1'b0;
      bus.result   <= '0;
      bus.overflow <= 1'b0;
    end else begin
      bus.ready <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.valid) begin
            a_q      <= bus.multiplicand;
            b_q      <= bus.multiplier;
            acc_q    <= {{WID{1'b0}}, bus.addend};
`ifdef RADIX4_EN
            a3_q     <= {2'b00, bus.multiplicand} + {1'b0, bus.multiplicand, 1'b0};
`endif
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_next_c;
          // Consumed multiplier bits shift out so the step always sees bit 0 up.
          b_q   <= b_q >> STEP_BITS;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(ITERS - 1)) begin
            bus.result   <= acc_next_c;
            bus.overflow <= |acc_next_c[ACC_W-1:WID];
            state        <= DONE;
          end
        end
        DONE: begin
          bus.ready <= 1'b1;
          bus.busy  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mac.sv
// Self-checking bench for shift_add_mac: directed spec vectors, random
// operands, request drop while busy / in DONE, mid-run reset, and divider
// loopback recomposition, all against a plain-arithmetic reference.
module tb_shift_add_mac;
  import srt_pkg::*;

  localparam int LAT_BUDGET = 300;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  shift_add_mac_if bus ();

  shift_add_mac dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mac_ref(input logic [63:0] a, input logic [63:0] b,
                                           input logic [63:0] c);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b};
    return p + {64'd0, c};
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Issues one request (DUT must be idle) and waits for ready.
  task automatic do_job(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                        output int lat, output logic [127:0] res, output logic ov,
                        output bit held);
    logic [127:0] prev;
    prev             = bus.result;
    held             = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.addend       = c;
    bus.valid        = 1'b1;
    @(posedge clk); #1;
    bus.valid        = 1'b0;
    bus.multiplicand = rand64();
    bus.multiplier   = rand64();
    bus.addend       = rand64();
    lat = -1;
    for (int n = 1; n <= LAT_BUDGET; n++) begin
      @(posedge clk); #1;
      if (bus.ready) begin
        lat = n;
        break;
      end
      if (n < int'(ITERS) && bus.result !== prev) held = 1'b0;
    end
    res = bus.result;
    ov  = bus.overflow;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.valid = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.addend       = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
    checks++; if (bus.result !== 128'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", bus.result); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [63:0]  va [3];
    logic [63:0]  vb [3];
    logic [63:0]  vc [3];
    logic [127:0] vexp [3];
    logic         vov [3];
    int lat; logic [127:0] res; logic ov; bit held;
    va[0] = 64'h1234; vb[0] = 64'h10; vc[0] = 64'h5;
    vexp[0] = 128'h12345; vov[0] = 1'b0;
    va[1] = '1; vb[1] = '1; vc[1] = '1;
    vexp[1] = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}; vov[1] = 1'b1;
    va[2] = 64'h0; vb[2] = 64'hFFFF; vc[2] = 64'h7;
    vexp[2] = 128'd7; vov[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_job(va[i], vb[i], vc[i], lat, res, ov, held);
      checks++; if (lat != int'(ITERS) + 1) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, int'(ITERS) + 1); end
      checks++; if (res !== vexp[i]) begin errors++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, vexp[i]); end
      checks++; if (ov !== vov[i]) begin errors++; $display("FAIL dir%0d_overflow got=%b exp=%b", i, ov, vov[i]); end
      checks++; if (!held) begin errors++; $display("FAIL dir%0d_result_held got=changed exp=stable", i); end
      // ready must be a single-cycle pulse with busy already low
      @(posedge clk); #1;
      checks++; if (bus.ready !== 1'b0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL dir%0d_pulse ready=%b busy=%b exp=0/0", i, bus.ready, bus.busy);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] a, b, c; logic [127:0] exp;
    int lat; logic [127:0] res; logic ov; bit held;
    for (int i = 0; i < 20; i++) begin
      a = rand64(); b = rand64(); c = rand64();
      if (i % 4 == 1) a = a >> $urandom_range(63, 1);
      if (i % 4 == 2) b = b >> $urandom_range(63, 1);
      exp = mac_ref(a, b, c);
      do_job(a, b, c, lat, res, ov, held);
      checks++; if (lat != int'(ITERS) + 1) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, int'(ITERS) + 1); end
      checks++; if (res !== exp) begin errors++; $display("FAIL rnd%0d_result got=%h exp=%h", i, res, exp); end
      checks++; if (ov !== (exp[127:64] != 64'd0)) begin errors++; $display("FAIL rnd%0d_overflow got=%b exp=%b", i, ov, exp[127:64] != 64'd0); end
    end
  endtask

  task automatic test_valid_while_busy();
    logic [63:0] a, b, c; logic [127:0] exp;
    int lat; int spurious;
    a = 64'hDEAD_BEEF_0123_4567; b = 64'h0000_0000_89AB_CDEF; c = 64'h1111;
    exp = mac_ref(a, b, c);
    bus.multiplicand = a; bus.multiplier = b; bus.addend = c; bus.valid = 1'b1;
    @(posedge clk); #1;
    bus.valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= LAT_BUDGET; n++) begin
      @(posedge clk); #1;
      if (bus.ready) begin lat = n; break; end
      bus.valid = (n == 9);
      if (n == 9) begin
        bus.multiplicand = 64'h5; bus.multiplier = 64'h7; bus.addend = 64'h9;
      end
    end
    bus.valid = 1'b0;
    checks++; if (lat != int'(ITERS) + 1) begin errors++; $display("FAIL busy_latency got=%0d exp=%0d", lat, int'(ITERS) + 1); end
    checks++; if (bus.result !== exp) begin errors++; $display("FAIL busy_result got=%h exp=%h", bus.result, exp); end
    spurious = 0;
    repeat (2 * ITERS + 4) begin
      @(posedge clk); #1;
      if (bus.ready) spurious++;
    end
    checks++; if (spurious != 0) begin errors++; $display("FAIL busy_dropped got=%0d extra ready exp=0", spurious); end
  endtask

  task automatic test_valid_in_done();
    logic [63:0] a, b, c; logic [127:0] exp;
    int lat; int spurious;
    a = rand64(); b = rand64(); c = rand64();
    exp = mac_ref(a, b, c);
    bus.multiplicand = a; bus.multiplier = b; bus.addend = c; bus.valid = 1'b1;
    @(posedge clk); #1;
    bus.valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= LAT_BUDGET; n++) begin
      @(posedge clk); #1;
      if (bus.ready) begin lat = n; break; end
      if (n == int'(ITERS)) begin
        bus.valid = 1'b1; bus.multiplicand = 64'h3; bus.multiplier = 64'h3; bus.addend = 64'h3;
      end
    end
    bus.valid = 1'b0;
    checks++; if (lat != int'(ITERS) + 1) begin errors++; $display("FAIL done_latency got=%0d exp=%0d", lat, int'(ITERS) + 1); end
    checks++; if (bus.result !== exp) begin errors++; $display("FAIL done_result got=%h exp=%h", bus.result, exp); end
    spurious = 0;
    repeat (2 * ITERS + 4) begin
      @(posedge clk); #1;
      if (bus.ready || bus.busy) spurious++;
    end
    checks++; if (spurious != 0) begin errors++; $display("FAIL done_dropped got=%0d active cycles exp=0", spurious); end
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] a, b, c; logic [127:0] exp;
    int lat; logic [127:0] res; logic ov; bit held; int spurious;
    bus.multiplicand = 64'hFFFF_0000_FFFF_0000; bus.multiplier = 64'h1234_5678_9ABC_DEF0;
    bus.addend = 64'h42; bus.valid = 1'b1;
    @(posedge clk); #1;
    bus.valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstrun_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL rstrun_ready got=%b exp=0", bus.ready); end
    checks++; if (bus.result !== 128'd0) begin errors++; $display("FAIL rstrun_result got=%h exp=0", bus.result); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rstrun_overflow got=%b exp=0", bus.overflow); end
    rst = 1'b0;
    spurious = 0;
    repeat (2 * ITERS + 4) begin
      @(posedge clk); #1;
      if (bus.ready) spurious++;
    end
    checks++; if (spurious != 0) begin errors++; $display("FAIL rstrun_no_ready got=%0d exp=0", spurious); end
    a = rand64(); b = rand64(); c = rand64();
    exp = mac_ref(a, b, c);
    do_job(a, b, c, lat, res, ov, held);
    checks++; if (lat != int'(ITERS) + 1) begin errors++; $display("FAIL rstrun_after_latency got=%0d exp=%0d", lat, int'(ITERS) + 1); end
    checks++; if (res !== exp) begin errors++; $display("FAIL rstrun_after_result got=%h exp=%h", res, exp); end
  endtask

  // Divider outputs modelled with plain / and %, recomposed back-to-back.
  task automatic test_loopback();
    logic [63:0] dividend, divisor, q, r;
    int lat; logic [127:0] res; logic ov; bit held;
    for (int i = 0; i < 300; i++) begin
      dividend = 64'hFF_FFFF + (rand64() % (64'hFF_FFFF_FFFF - 64'hFF_FFFF + 64'd1));
      divisor  = 64'd1 + (rand64() % 64'hFF_FFFF);
      q = dividend / divisor;
      r = dividend % divisor;
      do_job(q, divisor, r, lat, res, ov, held);
      checks++; if (lat != int'(ITERS) + 1) begin errors++; $display("FAIL loop%0d_latency got=%0d exp=%0d", i, lat, int'(ITERS) + 1); end
      checks++; if (res[63:0] !== dividend || ov !== 1'b0) begin
        errors++; $display("FAIL loop%0d_recompose got=%h ov=%b exp=%h ov=0", i, res[63:0], ov, dividend);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_valid_while_busy();
    test_valid_in_done();
    test_reset_mid_run();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
